alu_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU (operands A, B, 3-bit SEL, result Y) between two requesters.
- Round-robin grant, valid/ready handshake on request and response sides. Operands and result are registered.
- Sits between the ALU instance (external, combinational) and two client blocks. Drives the ALU A/B/SEL and samples Y.

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Round-robin grant on the request side and a valid/ready handshake on the
// response side. Operands and result are registered, so the ALU only ever
// sees the captured operands of the current owner.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; req_ready shows the one-hot grant
// EXEC  | ALU evaluating the latched operands (exactly one cycle)
// RESP  | result held on rsp_y, rsp_valid[owner] high until consumed
module alu_arbiter #(
  parameter int W  = 4,
  parameter int SW = 3,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*W-1:0]  req_a,
  input  logic [2*W-1:0]  req_b,
  input  logic [2*SW-1:0] req_sel,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [W-1:0]    rsp_y,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [SW-1:0]   alu_sel,
  input  logic [W-1:0]    alu_y,
  output logic            busy,
  output logic [CW-1:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ptr;
  logic            owner;
  logic            grant_vld;
  logic            grant_idx;
  logic            done;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [SW-1:0]   op_sel;
  logic [W-1:0]    result;
  logic [CW-1:0]   cnt;

  // Round-robin pick: pointer requester first, the other one as fallback.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr;
    if (req_valid[ptr]) begin
      grant_vld = 1'b1;
      grant_idx = ptr;
    end else if (req_valid[~ptr]) begin
      grant_vld = 1'b1;
      grant_idx = ~ptr;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept, result capture after EXEC, pointer and
  // completion count updated when the owner consumes its result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= '0;
      owner  <= 1'b0;
      result <= '0;
      ptr    <= 1'b0;
      cnt    <= '0;
    end else begin
      if (state == IDLE && grant_vld) begin
        op_a   <= grant_idx ? req_a[2*W-1:W]    : req_a[W-1:0];
        op_b   <= grant_idx ? req_b[2*W-1:W]    : req_b[W-1:0];
        op_sel <= grant_idx ? req_sel[2*SW-1:SW] : req_sel[SW-1:0];
        owner  <= grant_idx;
      end
      if (state == EXEC) result <= alu_y;
      if (done) begin
        ptr <= ~owner;
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_sel  = op_sel;
  assign rsp_y    = result;
  assign busy     = (state != IDLE);
  assign op_count = cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small combinational ALU attached.
module tb_alu_arbiter;

  localparam int W  = 4;
  localparam int SW = 3;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [2*SW-1:0] req_sel;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [W-1:0]    rsp_y;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [SW-1:0]   alu_sel;
  logic [W-1:0]    alu_y;
  logic            busy;
  logic [CW-1:0]   op_count;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_cnt;
  logic [3:0] sweep_exp [8];
  logic [1:0] rv_seen;

  always #5 clk = ~clk;

  // Reference ALU: add, sub, and, or, xor, not a, shl a, shr a.
  always_comb begin
    case (alu_sel)
      3'd0: alu_y = alu_a + alu_b;
      3'd1: alu_y = alu_a - alu_b;
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      3'd5: alu_y = ~alu_a;
      3'd6: alu_y = alu_a << 1;
      default: alu_y = alu_a >> 1;
    endcase
  end

  alu_arbiter #(.W(W), .SW(SW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    reset     = 1'b1;
    step();
    step();
    reset   = 1'b0;
    exp_cnt = 8'd0;
    step();
  endtask

  // One complete operation by a lone requester 0 with expected result.
  task automatic op0(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                     input logic [3:0] exp_y, input bit verbose);
    int n;
    req_a[3:0]   = a;
    req_b[3:0]   = b;
    req_sel[2:0] = sel;
    req_valid    = 2'b01;
    #1;
    n = 0;
    while (req_ready != 2'b01 && n < 10) begin
      step();
      n++;
    end
    if (verbose || n >= 10) chk("op0_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    req_a[3:0] = ~a;
    #1;
    if (verbose) begin
      chk("op0_exec_busy", busy, 1'b1);
      chk("op0_exec_ready", req_ready, 2'b00);
      chk("op0_alu_a", alu_a, a);
      chk("op0_alu_b", alu_b, b);
      chk("op0_alu_sel", alu_sel, sel);
      chk("op0_exec_rsp_valid", rsp_valid, 2'b00);
    end
    step();
    if (verbose) begin
      chk("op0_rsp_valid", rsp_valid, 2'b01);
      chk("op0_rsp_y", rsp_y, exp_y);
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    exp_cnt   = exp_cnt + 8'd1;
    #1;
    if (verbose) begin
      chk("op0_idle_busy", busy, 1'b0);
      chk("op0_idle_rsp_valid", rsp_valid, 2'b00);
      chk("op0_op_count", op_count, exp_cnt);
    end
  endtask

  initial begin
    req_a   = '0;
    req_b   = '0;
    req_sel = '0;
    reset   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #2;
    reset = 1'b1;
    #3;
    // reset state
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_y", rsp_y, 4'h0);
    chk("rst_op_count", op_count, 8'd0);
    chk("rst_alu_a", alu_a, 4'h0);
    chk("rst_alu_b", alu_b, 4'h0);
    chk("rst_alu_sel", alu_sel, 3'h0);
    do_reset();

    // Test 1: single operation, 1000 + 0111 = 1111
    op0(4'b1000, 4'b0111, 3'd0, 4'b1111, 1'b1);
    chk("t1_count", op_count, 8'd1);
    chk("t1_rsp_y_hold", rsp_y, 4'b1111);

    // Test 2: sweep all selects with a=1000 b=0111
    do_reset();
    sweep_exp[0] = 4'b1111; sweep_exp[1] = 4'b0001;
    sweep_exp[2] = 4'b0000; sweep_exp[3] = 4'b1111;
    sweep_exp[4] = 4'b1111; sweep_exp[5] = 4'b0111;
    sweep_exp[6] = 4'b0000; sweep_exp[7] = 4'b0100;
    for (int s = 0; s < 8; s++)
      op0(4'b1000, 4'b0111, 3'(s), sweep_exp[s], 1'b1);
    chk("t2_count", op_count, 8'd8);

    // Test 3: both requesting continuously; req0 3+2=5, req1 9|4=D
    do_reset();
    req_a   = {4'd9, 4'd3};
    req_b   = {4'd4, 4'd2};
    req_sel = {3'd3, 3'd0};
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("t3_exec_ready", req_ready, 2'b00);
      step();
      chk("t3_rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_rsp_y", rsp_y, (k % 2 == 0) ? 4'h5 : 4'hD);
      rsp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
      rsp_ready = 2'b00;
      #1;
    end
    chk("t3_count", op_count, 8'd4);
    req_valid = 2'b00;

    // Test 4: response stall with non-owner rsp_ready asserted
    do_reset();
    req_valid = 2'b11;
    #1;
    chk("t4_grant", req_ready, 2'b01);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      rsp_ready = (k % 2 == 0) ? 2'b00 : 2'b10;
      #1;
      chk("t4_stall_valid", rsp_valid, 2'b01);
      chk("t4_stall_y", rsp_y, 4'h5);
      chk("t4_stall_ready", req_ready, 2'b00);
      chk("t4_stall_busy", busy, 1'b1);
      step();
    end
    chk("t4_stall_count", op_count, 8'd0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    #1;
    chk("t4_release_busy", busy, 1'b0);
    chk("t4_release_valid", rsp_valid, 2'b00);
    chk("t4_next_grant", req_ready, 2'b10);
    chk("t4_count", op_count, 8'd1);
    req_valid = 2'b00;

    // Test 5: reset during EXEC then during RESP
    do_reset();
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    #1;
    chk("t5_in_exec", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5e_busy", busy, 1'b0);
    chk("t5e_alu_a", alu_a, 4'h0);
    chk("t5e_alu_b", alu_b, 4'h0);
    chk("t5e_rsp_valid", rsp_valid, 2'b00);
    rv_seen = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      rv_seen |= rsp_valid;
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      rv_seen |= rsp_valid;
    end
    chk("t5e_no_rsp", rv_seen, 2'b00);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    chk("t5r_in_resp", rsp_valid, 2'b10);
    reset = 1'b1;
    #1;
    chk("t5r_rsp_valid", rsp_valid, 2'b00);
    chk("t5r_rsp_y", rsp_y, 4'h0);
    chk("t5r_busy", busy, 1'b0);
    chk("t5r_count", op_count, 8'd0);
    step();
    reset = 1'b0;
    step();
    req_valid = 2'b11;
    #1;
    chk("t5_after_grant", req_ready, 2'b01);
    req_valid = 2'b00;

    // Test 6: op_count wrap after 256 completions
    do_reset();
    for (int k = 0; k < 255; k++)
      op0(4'd1, 4'd1, 3'd0, 4'd2, 1'b0);
    chk("t6_count_255", op_count, 8'd255);
    op0(4'd1, 4'd1, 3'd0, 4'd2, 1'b1);
    chk("t6_count_wrap", op_count, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
